// File: rtl/sweep_monitor.sv
// Watches a bounded up-counter. It checks that every sweep is a clean 0,1,2,... ramp
// followed by a return to 0, and it reports the peak and the number of completed sweeps.
module sweep_monitor #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic [N:0]   count_in,
    input  logic [N:0]   limit_in,
    output logic [N:0]   peak,
    output logic         peak_valid,
    output logic [W-1:0] sweep_count,
    output logic         tracking,
    output logic         step_error,
    output logic         limit_error
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    localparam logic [N:0]   VAL_ONE = 1;
    localparam logic [W-1:0] CNT_ONE = 1;

    state_t       state_q, state_d;
    logic [N:0]   prev_q, prev_d;
    logic [N:0]   peak_q, peak_d;
    logic         pv_q, pv_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         trk_q, trk_d;
    logic         serr_q, serr_d;
    logic         lerr_q, lerr_d;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == {W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    // An all-ones limit cannot be exceeded by one, so the counter tops out at the limit itself.
    function automatic logic [N:0] expected_peak(input logic [N:0] lim);
        return (lim == {(N+1){1'b1}}) ? lim : lim + VAL_ONE;
    endfunction

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        peak_d  = peak_q;
        pv_d    = 1'b0;
        cnt_d   = cnt_q;
        serr_d  = serr_q;
        lerr_d  = lerr_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            serr_d  = 1'b0;
            lerr_d  = 1'b0;
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (count_in == '0) begin
                        prev_d  = '0;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (count_in == '0 && prev_q != '0) begin
                        peak_d = prev_q;
                        pv_d   = 1'b1;
                        cnt_d  = sat_inc(cnt_q);
                        prev_d = '0;
                        if (prev_q != expected_peak(limit_in))
                            lerr_d = 1'b1;
                    end else if (count_in != '0 && count_in == prev_q + VAL_ONE) begin
                        prev_d = count_in;
                    end else begin
                        serr_d  = 1'b1;
                        state_d = FAULT;
                    end
                end
                default: ;
            endcase
        end
        trk_d = (state_d == TRACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prev_q  <= '0;
            peak_q  <= '0;
            pv_q    <= 1'b0;
            cnt_q   <= '0;
            trk_q   <= 1'b0;
            serr_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            peak_q  <= peak_d;
            pv_q    <= pv_d;
            cnt_q   <= cnt_d;
            trk_q   <= trk_d;
            serr_q  <= serr_d;
            lerr_q  <= lerr_d;
        end
    end

    assign peak        = peak_q;
    assign peak_valid  = pv_q;
    assign sweep_count = cnt_q;
    assign tracking    = trk_q;
    assign step_error  = serr_q;
    assign limit_error = lerr_q;

endmodule

// File: tb/tb_sweep_monitor.sv
// Directed bench for sweep_monitor: ramps, limit mismatch, illegal steps, wrap, gaps, saturation, reset abort.
module tb_sweep_monitor;

    logic       clk = 1'b0;
    logic       reset, en, clear;
    logic [3:0] count_in, limit_in;
    logic [3:0] peak, peak_s;
    logic       peak_valid, peak_valid_s;
    logic [7:0] sweep_count;
    logic [1:0] sweep_count_s;
    logic       tracking, step_error, limit_error;
    logic       tracking_s, step_error_s, limit_error_s;

    int checks = 0;
    int errors = 0;

    sweep_monitor #(.N(3), .W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .count_in(count_in), .limit_in(limit_in),
        .peak(peak), .peak_valid(peak_valid), .sweep_count(sweep_count),
        .tracking(tracking), .step_error(step_error), .limit_error(limit_error)
    );

    sweep_monitor #(.N(3), .W(2)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .count_in(count_in), .limit_in(limit_in),
        .peak(peak_s), .peak_valid(peak_valid_s), .sweep_count(sweep_count_s),
        .tracking(tracking_s), .step_error(step_error_s), .limit_error(limit_error_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c);
        count_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b1;
        clear = 1'b0;
        count_in = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] pk, input logic pv,
                              input logic [7:0] sc, input logic trk, input logic se, input logic le);
        chk({tag, ".peak"}, 32'(peak), 32'(pk));
        chk({tag, ".peak_valid"}, 32'(peak_valid), 32'(pv));
        chk({tag, ".sweep_count"}, 32'(sweep_count), 32'(sc));
        chk({tag, ".tracking"}, 32'(tracking), 32'(trk));
        chk({tag, ".step_error"}, 32'(step_error), 32'(se));
        chk({tag, ".limit_error"}, 32'(limit_error), 32'(le));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clear = 1'b0; count_in = 4'd7; limit_in = 4'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_outs("reset", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Test 1: legal ramp 0..6 with limit 5
        do_reset();
        limit_in = 4'd5;
        drive(4'd0);
        chk("t1.tracking_on", 32'(tracking), 32'd1);
        for (int i = 1; i <= 6; i++) drive(4'(i));
        chk("t1.no_pulse_mid", 32'(peak_valid), 32'd0);
        drive(4'd0);
        check_outs("t1.done", 4'd6, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        drive(4'd1);
        chk("t1.pulse_single", 32'(peak_valid), 32'd0);

        // Test 2: same ramp against limit 4
        do_reset();
        limit_in = 4'd4;
        for (int i = 0; i <= 6; i++) drive(4'(i));
        drive(4'd0);
        check_outs("t2.done", 4'd6, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);

        // Test 3: skipped value, then clear and recover
        do_reset();
        limit_in = 4'd0;
        drive(4'd0); drive(4'd1); drive(4'd2);
        chk("t3.no_err_yet", 32'(step_error), 32'd0);
        drive(4'd4);
        check_outs("t3.fault", 4'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        drive(4'd0);
        chk("t3.fault_holds", 32'(tracking), 32'd0);
        clear = 1'b1;
        drive(4'd5);
        clear = 1'b0;
        check_outs("t3.cleared", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        drive(4'd0); drive(4'd1); drive(4'd0);
        check_outs("t3.recover", 4'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        drive(4'd0);
        chk("t3.stuck_zero", 32'(step_error), 32'd1);

        // Test 4: full-range ramp with all-ones limit
        do_reset();
        limit_in = 4'd15;
        for (int i = 0; i <= 15; i++) drive(4'(i));
        drive(4'd0);
        check_outs("t4.wrap", 4'd15, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);

        // Test 5a: enable gaps inside two sweeps, limit 3 so peak 4 is legal
        do_reset();
        limit_in = 4'd3;
        drive(4'd0); drive(4'd1); drive(4'd2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) drive(4'd9);
        chk("t5.gap_hold_trk", 32'(tracking), 32'd1);
        chk("t5.gap_no_err", 32'(step_error), 32'd0);
        en = 1'b1;
        drive(4'd3); drive(4'd4); drive(4'd0);
        chk("t5.first_pulse", 32'(peak_valid), 32'd1);
        drive(4'd1); drive(4'd2);
        en = 1'b0;
        drive(4'd0);
        chk("t5.gap_no_pulse", 32'(peak_valid), 32'd0);
        drive(4'd0); drive(4'd0);
        en = 1'b1;
        drive(4'd3); drive(4'd4); drive(4'd0);
        check_outs("t5.two_sweeps", 4'd4, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        clear = 1'b1; en = 1'b0;
        drive(4'd0);
        clear = 1'b0; en = 1'b1;
        check_outs("t5.clear_keeps_peak", 4'd4, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Test 5b: five short sweeps, narrow counter saturates
        do_reset();
        limit_in = 4'd0;
        drive(4'd0);
        for (int s = 0; s < 5; s++) begin
            drive(4'd1);
            drive(4'd0);
        end
        chk("t5.wide_count", 32'(sweep_count), 32'd5);
        chk("t5.sat_count", 32'(sweep_count_s), 32'd3);
        chk("t5.sat_no_err", 32'(step_error_s), 32'd0);

        // Test 6: reset in the middle of a sweep
        do_reset();
        limit_in = 4'd0;
        drive(4'd0); drive(4'd1); drive(4'd2);
        reset = 1'b1;
        drive(4'd3);
        reset = 1'b0;
        check_outs("t6.reset_mid", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        drive(4'd0);
        chk("t6.no_abort_pulse", 32'(peak_valid), 32'd0);
        drive(4'd1); drive(4'd0);
        check_outs("t6.after", 4'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
